// File: rtl/cu_program_sequencer_if.sv
// -----------------------------------------------------------------------------
// cu_seq_if
// Bus between the program sequencer, its program ROM and the 4-bit
// computational unit (CU).
//
// Signals:
//   pm_addr    [7:0] ROM address (equals pc)             sequencer -> ROM
//   pm_data    [7:0] ROM word at pm_addr, async read     ROM -> sequencer
//   r_eq_0           registered CU zero flag             CU -> sequencer
//   pc         [7:0] program counter                     sequencer -> CU
//   sync_reset       clears the CU ALU result            sequencer -> CU
//   source_sel [3:0] data bus source select              sequencer -> CU
//   reg_en     [8:0] CU register write enables           sequencer -> CU
//                    (bit 7 = data-memory write enable)
//   i_sel, x_sel, y_sel  CU mux selects                  sequencer -> CU
//   ir_nibble  [3:0] immediate value or ALU function     sequencer -> CU
//   halted           high while in HALT                  sequencer -> CU
//   state_dbg  [1:0] sequencer FSM state (debug only)    sequencer -> any
//
// Handshake: there is none. ROM data is valid combinationally in the cycle its
// address is presented, and every control field is valid for the whole cycle
// and takes effect at the next rising clock edge.
//
// Modports: master = sequencer, slave = ROM/CU side.
// -----------------------------------------------------------------------------
interface cu_seq_if;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] pc;
  logic       sync_reset;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic [3:0] ir_nibble;
  logic       halted;
  logic [1:0] state_dbg;

  modport master (
    input  pm_data, r_eq_0,
    output pm_addr, pc, sync_reset, source_sel, reg_en,
           i_sel, x_sel, y_sel, ir_nibble, halted, state_dbg
  );

  modport slave (
    output pm_data, r_eq_0,
    input  pm_addr, pc, sync_reset, source_sel, reg_en,
           i_sel, x_sel, y_sel, ir_nibble, halted, state_dbg
  );
endinterface

// File: rtl/cu_program_sequencer.sv
// -----------------------------------------------------------------------------
// cu_program_sequencer
// Fetches 8-bit instructions from an async-read program ROM into an
// instruction register and decodes them into CU control fields. Supports
// two-word conditional jumps on r_eq_0 and a HALT state.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (forces INIT)
//   hold     (only with CU_SEQ_HOLD_EN) freezes state/pc/ir in EXEC or FILL
//   bus      cu_seq_if.master: ROM address/data, zero flag, control fields
//
// Optional build macro: CU_SEQ_HOLD_EN adds the hold input.
//
// In EXEC, pc already points at the word after ir, so a jump's target word
// is simply pm_data in its EXEC cycle.
// -----------------------------------------------------------------------------
module cu_program_sequencer (
  input  logic     clk,
  input  logic     reset_n,
`ifdef CU_SEQ_HOLD_EN
  input  logic     hold,
`endif
  cu_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_EXEC = 2'd1,
    S_FILL = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;

  logic [2:0] ddd;
  logic [2:0] sss;
  logic       is_ctrl;
  logic       is_jump;
  logic       is_halt;
  logic       jump_taken;
  logic       hold_act;

  assign ddd = ir_q[5:3];
  assign sss = ir_q[2:0];

  // Control ops share the move encoding with ddd == sss; ddd == 6 is i <= i+m.
  assign is_ctrl    = (ir_q[7:6] == 2'b10) && (ddd == sss) && (ddd != 3'd6);
  assign is_jump    = is_ctrl && (ddd <= 3'd2);
  assign is_halt    = is_ctrl && (ddd == 3'd7);
  assign jump_taken = (ddd == 3'd0) ||
                      ((ddd == 3'd1) &&  bus.r_eq_0) ||
                      ((ddd == 3'd2) && !bus.r_eq_0);

`ifdef CU_SEQ_HOLD_EN
  assign hold_act = hold && ((state_q == S_EXEC) || (state_q == S_FILL));
`else
  assign hold_act = 1'b0;
`endif

  // Destination code to write-enable bit; code 4 is the data-memory write
  // (bit 7) and code 7 the output register (bit 8), bit 4 belongs to r.
  function automatic logic [8:0] dest_onehot(input logic [2:0] d);
    logic [8:0] oh;
    oh = 9'h000;
    case (d)
      3'd4:    oh[7] = 1'b1;
      3'd7:    oh[8] = 1'b1;
      default: oh[d] = 1'b1;
    endcase
    return oh;
  endfunction

  // Sequencing: state, pc and ir
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
    end else if (!hold_act) begin
      case (state_q)
        S_INIT, S_FILL: begin
          ir_q    <= bus.pm_data;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_jump) begin
            pc_q    <= jump_taken ? bus.pm_data : (pc_q + 8'd1);
            state_q <= S_FILL;
          end else if (is_halt) begin
            state_q <= S_HALT;
          end else begin
            ir_q <= bus.pm_data;
            pc_q <= pc_q + 8'd1;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Control decode, combinational from state and ir
  logic       sync_reset;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic [3:0] ir_nibble;

  always_comb begin
    sync_reset = 1'b0;
    source_sel = 4'd0;
    reg_en     = 9'h000;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    ir_nibble  = 4'd0;
    case (state_q)
      S_INIT: begin
        sync_reset = 1'b1;
        reg_en     = 9'h010;
      end
      S_EXEC: begin
        if (!ir_q[7]) begin
          source_sel = 4'd8;
          ir_nibble  = ir_q[3:0];
          reg_en     = dest_onehot(ir_q[6:4]);
        end else if (ir_q[6]) begin
          x_sel     = ir_q[5];
          y_sel     = ir_q[4];
          ir_nibble = ir_q[3:0];
          reg_en    = 9'h010;
        end else if (ddd != sss) begin
          source_sel = {1'b0, sss};
          reg_en     = dest_onehot(ddd);
        end else if (ddd == 3'd6) begin
          i_sel  = 1'b1;
          reg_en = 9'h040;
        end
        if (hold_act) begin
          reg_en     = 9'h000;
          sync_reset = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.pm_addr    = pc_q;
  assign bus.pc         = pc_q;
  assign bus.sync_reset = sync_reset;
  assign bus.source_sel = source_sel;
  assign bus.reg_en     = reg_en;
  assign bus.i_sel      = i_sel;
  assign bus.x_sel      = x_sel;
  assign bus.y_sel      = y_sel;
  assign bus.ir_nibble  = ir_nibble;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_cu_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_program_sequencer
// Directed bench for cu_program_sequencer with a small ROM model. Outputs are
// sampled on the falling clock edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_cu_program_sequencer;

  logic       clk;
  logic       reset_n;
  logic [7:0] rom [256];
  int         checks;
  int         failures;
`ifdef CU_SEQ_HOLD_EN
  logic       hold;
`endif

  cu_seq_if bus ();

  assign bus.pm_data = rom[bus.pm_addr];

  cu_program_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CU_SEQ_HOLD_EN
    .hold    (hold),
`endif
    .bus     (bus.master)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic [7:0] e_pc, input logic e_sr,
                      input logic [3:0] e_ss, input logic [8:0] e_re,
                      input logic e_isel, input logic e_xsel, input logic e_ysel,
                      input logic [3:0] e_nib, input logic e_halt);
    chk({tag, ".pc"},         {24'd0, bus.pc},         {24'd0, e_pc});
    chk({tag, ".pm_addr"},    {24'd0, bus.pm_addr},    {24'd0, e_pc});
    chk({tag, ".sync_reset"}, {31'd0, bus.sync_reset}, {31'd0, e_sr});
    chk({tag, ".source_sel"}, {28'd0, bus.source_sel}, {28'd0, e_ss});
    chk({tag, ".reg_en"},     {23'd0, bus.reg_en},     {23'd0, e_re});
    chk({tag, ".sel"},        {29'd0, bus.i_sel, bus.x_sel, bus.y_sel},
                              {29'd0, e_isel, e_xsel, e_ysel});
    chk({tag, ".ir_nibble"},  {28'd0, bus.ir_nibble},  {28'd0, e_nib});
    chk({tag, ".halted"},     {31'd0, bus.halted},     {31'd0, e_halt});
  endtask

  // hold reset for two cycles, then release just after a rising edge
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    ctrl("rst_held", 8'h00, 1'b1, 4'd0, 9'h010, 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
`ifdef CU_SEQ_HOLD_EN
    hold     = 1'b0;
`endif
    bus.r_eq_0 = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h05;  // load x0, 5
    rom[8'h01] = 8'h12;  // load x1, 2
    rom[8'h02] = 8'hC2;  // ALU x0,y0 fn 2
    rom[8'h03] = 8'hB6;  // i <= i + m
    rom[8'h04] = 8'h89;  // JZ
    rom[8'h05] = 8'h20;  //   target
    rom[8'h06] = 8'h61;  // load i, 1
    rom[8'h07] = 8'hBF;  // HALT
    rom[8'h20] = 8'hA3;  // move dm <= y1
    rom[8'h21] = 8'h80;  // JMP
    rom[8'h22] = 8'hFF;  //   target
    rom[8'hFF] = 8'h00;  // load x0, 0

    // ---- run 1: r_eq_0 = 1, JZ taken, then JMP wrap ----
    do_reset();
    @(negedge clk); ctrl("init",   8'h01 - 8'h01, 1, 4'd0, 9'h010, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("ld05",   8'h01, 0, 4'd8, 9'h001, 0, 0, 0, 4'd5, 0);
    @(negedge clk); ctrl("ld12",   8'h02, 0, 4'd8, 9'h002, 0, 0, 0, 4'd2, 0);
    @(negedge clk); ctrl("aluC2",  8'h03, 0, 4'd0, 9'h010, 0, 0, 0, 4'd2, 0);
    @(negedge clk); ctrl("imB6",   8'h04, 0, 4'd0, 9'h040, 1, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("jz_t",   8'h05, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("fill_t", 8'h20, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("mvA3",   8'h21, 0, 4'd3, 9'h080, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("jmp",    8'h22, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("fill_w", 8'hFF, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("wrap",   8'h00, 0, 4'd8, 9'h001, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("ld05w",  8'h01, 0, 4'd8, 9'h001, 0, 0, 0, 4'd5, 0);

    // ---- run 2: r_eq_0 = 0, JZ not taken, HALT ----
    bus.r_eq_0 = 1'b0;
    do_reset();
    @(negedge clk); ctrl("init2",  8'h00, 1, 4'd0, 9'h010, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("ld05_2", 8'h01, 0, 4'd8, 9'h001, 0, 0, 0, 4'd5, 0);
    @(negedge clk); ctrl("ld12_2", 8'h02, 0, 4'd8, 9'h002, 0, 0, 0, 4'd2, 0);
    @(negedge clk); ctrl("aluC2_2",8'h03, 0, 4'd0, 9'h010, 0, 0, 0, 4'd2, 0);
    @(negedge clk);
`ifdef CU_SEQ_HOLD_EN
    hold = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold.pc",     {24'd0, bus.pc},     32'h04);
      chk("hold.reg_en", {23'd0, bus.reg_en}, 32'h000);
    end
    hold = 1'b0;
    #1;
`endif
    ctrl("imB6_2", 8'h04, 0, 4'd0, 9'h040, 1, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("jz_nt",  8'h05, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("fill_nt",8'h06, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("ld61",   8'h07, 0, 4'd8, 9'h040, 0, 0, 0, 4'd1, 0);
    @(negedge clk); ctrl("haltex", 8'h08, 0, 4'd0, 9'h000, 0, 0, 0, 4'd0, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("halt.halted", {31'd0, bus.halted}, 32'd1);
      chk("halt.reg_en", {23'd0, bus.reg_en}, 32'h000);
      chk("halt.pc",     {24'd0, bus.pc},     32'h08);
    end

    // asynchronous reset while halted, mid-cycle
    #2 reset_n = 1'b0;
    #1 ctrl("async_rst", 8'h00, 1, 4'd0, 9'h010, 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); ctrl("init3",  8'h00, 1, 4'd0, 9'h010, 0, 0, 0, 4'd0, 0);
    @(negedge clk); ctrl("ld05_3", 8'h01, 0, 4'd8, 9'h001, 0, 0, 0, 4'd5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
